memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
//  MEM pipeline stage; consumer side of the EX->MEM interface. Latches EXMEM_* each accepted cycle.
//  Non-memory ops pass through in 1 cycle. Loads/stores go through a req/gnt/rvalid data-memory handshake.
//  Produces MEMEX_stall/rd/rdval/wbactive back to EX (stall + forwarding) and MEMWB_* toward writeback.
// PARAMETERS
//  XLEN      64   data/address width (only 64 supported)
//  MAX_WAIT  255  cycles in REQ+WAIT before abort with fault (8-bit counter)
// PORTS
//  clk             in   1     clock; all state on posedge
//  reset           in   1     synchronous, active-high
//  EXMEM_ready     in   1     EX holds a valid instruction
//  exmm_aluresult  in   64    ALU result, or effective address if mem_active
//  EXMEM_rs2       in   64    store data
//  dest_reg        in   6     destination register
//  mem_active      in   1     load/store
//  load            in   1     1=load, 0=store (valid when mem_active)
//  ldst_size       in   8     8/16/32/64 access bits
//  ldst_unsign     in   1     zero-extend load
//  EXMEM_wbactive  in   1     instruction writes rd
//  EXMEM_ecall     in   1     ecall marker
//  MEMEX_stall     out  1     EX must hold
//  MEMEX_rd        out  6     forwarding register index
//  MEMEX_rdval     out  64    forwarding value
//  MEMEX_wbactive  out  1     forwarding value valid
//  dmem_req/dmem_we out 1/1   request valid / write
//  dmem_addr       out  64    8-byte-aligned address
//  dmem_wdata      out  64    lane-shifted store data
//  dmem_wstrb      out  8     byte strobes
//  dmem_gnt        in   1     request accepted this cycle
//  dmem_rvalid     in   1     load data valid
//  dmem_rdata      in   64    load data (aligned doubleword)
//  MEMWB_ready     out  1     1-cycle pulse per completed instruction
//  MEMWB_rd/rdval  out  6/64  writeback index/value
//  MEMWB_wbactive  out  1     writeback enable
//  MEMWB_ecall     out  1     ecall passed through
//  mem_fault       out  1     timeout/misalign abort, with MEMWB_ready
// BEHAVIOUR
//  Reset: state IDLE; every output 0; held instr regs cleared; late rvalid ignored. Reset mid-transaction
//   drops dmem_req on that same edge.
//  FSM IDLE->REQ->WAIT->IDLE. Capture only in IDLE with EXMEM_ready=1.
//  IDLE: non-mem capture at edge N -> after N: MEMWB_ready=1, rdval=aluresult, wbactive/ecall copied.
//   Mem capture -> REQ.
//  REQ: dmem_req=1, addr/data/strb stable until dmem_gnt sampled.
//   Store+gnt -> IDLE, MEMWB_ready=1, wbactive=0. Load+gnt -> WAIT.
//  WAIT: dmem_rvalid -> lane extract + extend -> MEMWB_rdval, MEMWB_ready=1, -> IDLE.
//   rvalid outside WAIT is ignored.
//  MEMEX_stall = (state!=IDLE), combinational. Min load 3 cycles from capture (gnt+rvalid next cycle);
//   1 bubble after completion.
//  Forwarding: MEMEX_rd=held rd; MEMEX_rdval=MEMWB_rdval; MEMEX_wbactive=held wbactive & result valid.
//   Load wbactive=0 until rvalid.
//  off=addr[2:0]; dmem_addr={addr[63:3],3'b0}. wstrb: 8->1<<off, 16->3<<off, 32->F<<off, 64->FF.
//   wdata=rs2<<(8*off). Any other ldst_size is treated as 64.
//  Load: rdata>>(8*off), take low size bits, sign-extend unless ldst_unsign (64: no extension).
//  Timeout: counter clears on entering REQ, counts in REQ/WAIT. Reaching MAX_WAIT -> IDLE,
//   MEMWB_ready=1, mem_fault=1, wbactive=0.
//  rd==0: wbactive is forced to 0 on both MEMWB and MEMEX.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined: access with off not a multiple of size/8 issues no request;
//   next cycle MEMWB_ready=1, mem_fault=1, wbactive=0.
//  Not defined: misaligned access is issued. Strobe/data bits shifted past byte 7 are dropped;
//   load returns the available bytes, zero-filled above them before extension. mem_fault is only
//   ever set by timeout.
// TESTING
//  add: aluresult=0x1234, rd=5 -> next cycle MEMWB_ready=1, rdval=0x1234, MEMEX_stall=0.
//  lb: addr=0x1003, rdata=0x00000000_80000000 -> rdval=0xFFFF_FFFF_FFFF_FF80; lbu -> 0x80;
//   stall high 3 cycles.
//  sh: addr=0x2006, rs2=0xBEEF -> dmem_addr=0x2000, wstrb=0xC0, wdata[63:48]=0xBEEF, we=1, wbactive=0.
//  Load with gnt delayed 4 cycles -> req held, addr stable, EX held; forwarded value appears on
//   MEMEX_rdval with MEMEX_wbactive=1.
//  No gnt for 255 cycles -> mem_fault=1 pulse, state IDLE, stall drops. Reset asserted in WAIT,
//   then rvalid -> ignored, all outputs 0.
//  lw at addr=0x3002 with MEM_MISALIGN_TRAP_EN -> no dmem_req, mem_fault=1.
//   Without the macro -> wstrb/lane per the truncation rule.

Source files
------------

// File: rtl/memory_stage_if.sv
// Bundles for the MEM stage: EX<->MEM handshake/forwarding, data-memory port, and writeback.
// The master modport is the driving side of each bundle's request direction.
interface memory_stage_ex_if #(parameter int XLEN = 64);
    logic            EXMEM_ready;
    logic [XLEN-1:0] exmm_aluresult;
    logic [XLEN-1:0] EXMEM_rs2;
    logic [5:0]      dest_reg;
    logic            mem_active;
    logic            load;
    logic [7:0]      ldst_size;
    logic            ldst_unsign;
    logic            EXMEM_wbactive;
    logic            EXMEM_ecall;
    logic            MEMEX_stall;
    logic [5:0]      MEMEX_rd;
    logic [XLEN-1:0] MEMEX_rdval;
    logic            MEMEX_wbactive;

    modport master (
        output EXMEM_ready, exmm_aluresult, EXMEM_rs2, dest_reg, mem_active, load,
               ldst_size, ldst_unsign, EXMEM_wbactive, EXMEM_ecall,
        input  MEMEX_stall, MEMEX_rd, MEMEX_rdval, MEMEX_wbactive
    );
    modport slave (
        input  EXMEM_ready, exmm_aluresult, EXMEM_rs2, dest_reg, mem_active, load,
               ldst_size, ldst_unsign, EXMEM_wbactive, EXMEM_ecall,
        output MEMEX_stall, MEMEX_rd, MEMEX_rdval, MEMEX_wbactive
    );
endinterface

interface memory_stage_dmem_if #(parameter int XLEN = 64);
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [7:0]      dmem_wstrb;
    logic            dmem_gnt;
    logic            dmem_rvalid;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );
    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

interface memory_stage_wb_if #(parameter int XLEN = 64);
    logic            MEMWB_ready;
    logic [5:0]      MEMWB_rd;
    logic [XLEN-1:0] MEMWB_rdval;
    logic            MEMWB_wbactive;
    logic            MEMWB_ecall;
    logic            mem_fault;

    modport master (
        output MEMWB_ready, MEMWB_rd, MEMWB_rdval, MEMWB_wbactive, MEMWB_ecall, mem_fault
    );
    modport slave (
        input  MEMWB_ready, MEMWB_rd, MEMWB_rdval, MEMWB_wbactive, MEMWB_ecall, mem_fault
    );
endinterface

// File: rtl/memory_stage.sv
// MEM pipeline stage: 1-cycle pass-through for ALU ops, req/gnt/rvalid handshake for loads/stores.
// Define MEM_MISALIGN_TRAP_EN to fault misaligned accesses instead of issuing them truncated.
module memory_stage #(
    parameter int XLEN     = 64,
    parameter int MAX_WAIT = 255
) (
    input  logic                clk,
    input  logic                reset,
    memory_stage_ex_if.slave    exBus,
    memory_stage_dmem_if.master dmemBus,
    memory_stage_wb_if.master   wbBus
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t          state_q,    state_d;
    logic [5:0]      rd_q,       rd_d;
    logic            wbAct_q,    wbAct_d;
    logic            ecall_q,    ecall_d;
    logic            load_q,     load_d;
    logic [1:0]      size_q,     size_d;
    logic            unsign_q,   unsign_d;
    logic [2:0]      off_q,      off_d;
    logic [XLEN-1:0] addr_q,     addr_d;
    logic [XLEN-1:0] wdata_q,    wdata_d;
    logic [7:0]      wstrb_q,    wstrb_d;
    logic [7:0]      cnt_q,      cnt_d;
    logic [XLEN-1:0] rdval_q,    rdval_d;
    logic            ready_q,    ready_d;
    logic            fault_q,    fault_d;
    logic            resValid_q, resValid_d;

    logic [1:0]      capSize;
    logic [2:0]      capOff;
    logic [7:0]      capStrb;
    logic [XLEN-1:0] capWdata;
    logic [XLEN-1:0] loadShift;
    logic [XLEN-1:0] loadVal;
    logic            timeout;

    // Size code 0..3 = byte/half/word/double; unrecognised sizes behave as a doubleword.
    always_comb begin
        capSize = 2'd3;
        case (exBus.ldst_size)
            8'd8:    capSize = 2'd0;
            8'd16:   capSize = 2'd1;
            8'd32:   capSize = 2'd2;
            default: capSize = 2'd3;
        endcase
        capOff = exBus.exmm_aluresult[2:0];
        case (capSize)
            2'd0:    capStrb = 8'h01 << capOff;
            2'd1:    capStrb = 8'h03 << capOff;
            2'd2:    capStrb = 8'h0F << capOff;
            default: capStrb = 8'hFF;
        endcase
        capWdata = exBus.EXMEM_rs2 << {capOff, 3'b000};
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic capMisalign;
    always_comb begin
        case (capSize)
            2'd1:    capMisalign = capOff[0];
            2'd2:    capMisalign = |capOff[1:0];
            2'd3:    capMisalign = |capOff;
            default: capMisalign = 1'b0;
        endcase
    end
`endif

    // Bytes beyond lane 7 shift in as zeros, so a truncated load extends from a zero-filled top.
    always_comb begin
        loadShift = dmemBus.dmem_rdata >> {off_q, 3'b000};
        case (size_q)
            2'd0:    loadVal = {{56{~unsign_q & loadShift[7]}},  loadShift[7:0]};
            2'd1:    loadVal = {{48{~unsign_q & loadShift[15]}}, loadShift[15:0]};
            2'd2:    loadVal = {{32{~unsign_q & loadShift[31]}}, loadShift[31:0]};
            default: loadVal = loadShift;
        endcase
    end

    assign timeout = (cnt_q == 8'(MAX_WAIT - 1));

    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        wbAct_d    = wbAct_q;
        ecall_d    = ecall_q;
        load_d     = load_q;
        size_d     = size_q;
        unsign_d   = unsign_q;
        off_d      = off_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        cnt_d      = cnt_q;
        rdval_d    = rdval_q;
        resValid_d = resValid_q;
        ready_d    = 1'b0;
        fault_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (exBus.EXMEM_ready) begin
                    rd_d    = exBus.dest_reg;
                    wbAct_d = exBus.EXMEM_wbactive & (exBus.dest_reg != 6'd0);
                    ecall_d = exBus.EXMEM_ecall;
                    if (!exBus.mem_active) begin
                        rdval_d    = exBus.exmm_aluresult;
                        resValid_d = 1'b1;
                        ready_d    = 1'b1;
                    end else begin
                        resValid_d = 1'b0;
                        load_d     = exBus.load;
                        size_d     = capSize;
                        unsign_d   = exBus.ldst_unsign;
                        off_d      = capOff;
                        addr_d     = {exBus.exmm_aluresult[XLEN-1:3], 3'b000};
                        wdata_d    = capWdata;
                        wstrb_d    = capStrb;
                        cnt_d      = 8'd0;
`ifdef MEM_MISALIGN_TRAP_EN
                        if (capMisalign) begin
                            ready_d = 1'b1;
                            fault_d = 1'b1;
                        end else begin
                            state_d = REQ;
                        end
`else
                        state_d = REQ;
`endif
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + 8'd1;
                if (dmemBus.dmem_gnt) begin
                    if (load_q) begin
                        state_d = WAIT;
                    end else begin
                        state_d = IDLE;
                        ready_d = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    fault_d = 1'b1;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (dmemBus.dmem_rvalid) begin
                    state_d    = IDLE;
                    rdval_d    = loadVal;
                    resValid_d = 1'b1;
                    ready_d    = 1'b1;
                end else if (timeout) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    fault_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rd_q       <= '0;
            wbAct_q    <= 1'b0;
            ecall_q    <= 1'b0;
            load_q     <= 1'b0;
            size_q     <= '0;
            unsign_q   <= 1'b0;
            off_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            cnt_q      <= '0;
            rdval_q    <= '0;
            ready_q    <= 1'b0;
            fault_q    <= 1'b0;
            resValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            wbAct_q    <= wbAct_d;
            ecall_q    <= ecall_d;
            load_q     <= load_d;
            size_q     <= size_d;
            unsign_q   <= unsign_d;
            off_q      <= off_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            cnt_q      <= cnt_d;
            rdval_q    <= rdval_d;
            ready_q    <= ready_d;
            fault_q    <= fault_d;
            resValid_q <= resValid_d;
        end
    end

    assign exBus.MEMEX_stall    = (state_q != IDLE);
    assign exBus.MEMEX_rd       = rd_q;
    assign exBus.MEMEX_rdval    = rdval_q;
    assign exBus.MEMEX_wbactive = wbAct_q & resValid_q;

    assign dmemBus.dmem_req   = (state_q == REQ);
    assign dmemBus.dmem_we    = (state_q == REQ) & ~load_q;
    assign dmemBus.dmem_addr  = addr_q;
    assign dmemBus.dmem_wdata = wdata_q;
    assign dmemBus.dmem_wstrb = wstrb_q;

    assign wbBus.MEMWB_ready    = ready_q;
    assign wbBus.MEMWB_rd       = rd_q;
    assign wbBus.MEMWB_rdval    = rdval_q;
    assign wbBus.MEMWB_wbactive = wbAct_q & resValid_q;
    assign wbBus.MEMWB_ecall    = ecall_q;
    assign wbBus.mem_fault      = fault_q;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: a delayed-grant memory responder plus one task per scenario.
module tb_memory_stage;

    logic clk;
    logic reset;

    memory_stage_ex_if   exIf ();
    memory_stage_dmem_if dmemIf ();
    memory_stage_wb_if   wbIf ();

    memory_stage dut (
        .clk     (clk),
        .reset   (reset),
        .exBus   (exIf.slave),
        .dmemBus (dmemIf.master),
        .wbBus   (wbIf.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] rdval;
        logic        checkVal;
        logic        wb;
        logic        fault;
        logic [5:0]  rd;
    } exp_t;

    exp_t sbQ[$];
    int   total = 0;
    int   bad   = 0;

    int          gntDelay   = 0;
    bit          noGnt      = 0;
    bit          noRvalid   = 0;
    bit          pendRvalid = 0;
    bit          inReq      = 0;
    bit          addrMoved  = 0;
    int          waitCnt    = 0;
    int          reqCycles  = 0;
    logic [63:0] memData    = '0;
    logic [63:0] firstAddr  = '0;
    logic [63:0] gotAddr    = '0;
    logic [63:0] gotWdata   = '0;
    logic [7:0]  gotStrb    = '0;
    logic        gotWe      = 1'b0;

    // Data-memory responder: grants after gntDelay request cycles, returns load data the cycle after.
    initial begin
        dmemIf.dmem_gnt    = 1'b0;
        dmemIf.dmem_rvalid = 1'b0;
        dmemIf.dmem_rdata  = '0;
        forever begin
            @(negedge clk);
            dmemIf.dmem_gnt    = 1'b0;
            dmemIf.dmem_rvalid = 1'b0;
            if (reset) begin
                waitCnt = 0;
                inReq   = 0;
            end else if (pendRvalid && !noRvalid) begin
                dmemIf.dmem_rvalid = 1'b1;
                dmemIf.dmem_rdata  = memData;
                pendRvalid         = 0;
            end else if (dmemIf.dmem_req) begin
                reqCycles++;
                if (!inReq) begin
                    inReq     = 1;
                    firstAddr = dmemIf.dmem_addr;
                end else if (dmemIf.dmem_addr !== firstAddr) begin
                    addrMoved = 1;
                end
                if (!noGnt) begin
                    if (waitCnt >= gntDelay) begin
                        dmemIf.dmem_gnt = 1'b1;
                        waitCnt         = 0;
                        inReq           = 0;
                        pendRvalid      = !dmemIf.dmem_we;
                        gotAddr         = dmemIf.dmem_addr;
                        gotWdata        = dmemIf.dmem_wdata;
                        gotStrb         = dmemIf.dmem_wstrb;
                        gotWe           = dmemIf.dmem_we;
                    end else begin
                        waitCnt++;
                    end
                end
            end
        end
    end

    function automatic int bytesOf(input logic [7:0] size);
        if (size == 8'd8)  return 1;
        if (size == 8'd16) return 2;
        if (size == 8'd32) return 4;
        return 8;
    endfunction

    function automatic logic [63:0] expLoad(input logic [63:0] rdata, input logic [2:0] off,
                                            input logic [7:0] size, input logic uns);
        int          nb;
        logic [63:0] v;
        nb = bytesOf(size);
        v  = '0;
        for (int i = 0; i < nb; i++)
            if (int'(off) + i < 8) v[8*i +: 8] = rdata[8*(int'(off) + i) +: 8];
        if (!uns && nb < 8 && v[8*nb-1])
            for (int b = 8 * nb; b < 64; b++) v[b] = 1'b1;
        return v;
    endfunction

    function automatic logic [7:0] expStrb(input logic [2:0] off, input logic [7:0] size);
        int         nb;
        logic [7:0] s;
        nb = bytesOf(size);
        if (nb == 8) return 8'hFF;
        s = '0;
        for (int i = 0; i < nb; i++)
            if (int'(off) + i < 8) s[int'(off) + i] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] expWdata(input logic [63:0] rs2, input logic [2:0] off);
        logic [63:0] w;
        w = '0;
        for (int j = int'(off); j < 8; j++) w[8*j +: 8] = rs2[8*(j - int'(off)) +: 8];
        return w;
    endfunction

    // Presents one instruction for a single cycle; caller guarantees MEMEX_stall is low.
    task automatic applyStimulus(input logic mem, input logic ld, input logic [7:0] size,
                                 input logic uns, input logic [63:0] alu, input logic [63:0] rs2,
                                 input logic [5:0] rd, input logic wbact, input logic ecall);
        exIf.EXMEM_ready    = 1'b1;
        exIf.mem_active     = mem;
        exIf.load           = ld;
        exIf.ldst_size      = size;
        exIf.ldst_unsign    = uns;
        exIf.exmm_aluresult = alu;
        exIf.EXMEM_rs2      = rs2;
        exIf.dest_reg       = rd;
        exIf.EXMEM_wbactive = wbact;
        exIf.EXMEM_ecall    = ecall;
        @(negedge clk);
        exIf.EXMEM_ready    = 1'b0;
        exIf.mem_active     = 1'b0;
        exIf.EXMEM_wbactive = 1'b0;
        exIf.EXMEM_ecall    = 1'b0;
    endtask

    task automatic waitReady(input int budget, output int stallCycles, output bit timedOut,
                             output bit fwdEarly);
        stallCycles = 0;
        timedOut    = 0;
        fwdEarly    = 0;
        for (int i = 0; i <= budget; i++) begin
            if (wbIf.MEMWB_ready) return;
            if (exIf.MEMEX_stall) stallCycles++;
            if (exIf.MEMEX_stall && exIf.MEMEX_wbactive) fwdEarly = 1;
            @(negedge clk);
        end
        timedOut = 1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, 64'hDEAD, 64'h0, 6'd3, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        total++;
        if (exIf.MEMEX_stall !== 1'b0 || exIf.MEMEX_wbactive !== 1'b0 || exIf.MEMEX_rd !== 6'd0) begin
            bad++;
            $display("[TB] FAIL reset_memex got stall=%b wb=%b rd=%0d exp 0/0/0",
                     exIf.MEMEX_stall, exIf.MEMEX_wbactive, exIf.MEMEX_rd);
        end
        total++;
        if ({wbIf.MEMWB_ready, wbIf.MEMWB_wbactive, wbIf.MEMWB_ecall, wbIf.mem_fault} !== 4'b0000 ||
            wbIf.MEMWB_rdval !== 64'h0) begin
            bad++;
            $display("[TB] FAIL reset_memwb got rdy=%b wb=%b ec=%b flt=%b val=%h exp all 0",
                     wbIf.MEMWB_ready, wbIf.MEMWB_wbactive, wbIf.MEMWB_ecall, wbIf.mem_fault,
                     wbIf.MEMWB_rdval);
        end
        total++;
        if ({dmemIf.dmem_req, dmemIf.dmem_we, dmemIf.dmem_wstrb} !== 10'h0 ||
            dmemIf.dmem_addr !== 64'h0 || dmemIf.dmem_wdata !== 64'h0) begin
            bad++;
            $display("[TB] FAIL reset_dmem got req=%b we=%b strb=%h addr=%h exp all 0",
                     dmemIf.dmem_req, dmemIf.dmem_we, dmemIf.dmem_wstrb, dmemIf.dmem_addr);
        end
    endtask

    task automatic test_alu();
        exp_t e;
        int   st;
        bit   to, fe;
        sbQ.push_back('{rdval: 64'h1234, checkVal: 1'b1, wb: 1'b1, fault: 1'b0, rd: 6'd5});
        applyStimulus(1'b0, 1'b0, 8'd64, 1'b0, 64'h1234, 64'h0, 6'd5, 1'b1, 1'b0);
        waitReady(0, st, to, fe);
        e = sbQ.pop_front();
        total++;
        if (to || st != 0) begin
            bad++;
            $display("[TB] FAIL alu_latency got timeout=%b stall=%0d exp ready next cycle", to, st);
        end
        total++;
        if (wbIf.MEMWB_rdval !== e.rdval || wbIf.MEMWB_wbactive !== e.wb || wbIf.MEMWB_rd !== e.rd) begin
            bad++;
            $display("[TB] FAIL alu_result got val=%h wb=%b rd=%0d exp val=%h wb=%b rd=%0d",
                     wbIf.MEMWB_rdval, wbIf.MEMWB_wbactive, wbIf.MEMWB_rd, e.rdval, e.wb, e.rd);
        end
        total++;
        if (exIf.MEMEX_rdval !== e.rdval || exIf.MEMEX_wbactive !== 1'b1 || exIf.MEMEX_stall !== 1'b0) begin
            bad++;
            $display("[TB] FAIL alu_forward got val=%h wb=%b stall=%b exp val=%h wb=1 stall=0",
                     exIf.MEMEX_rdval, exIf.MEMEX_wbactive, exIf.MEMEX_stall, e.rdval);
        end
        @(negedge clk);
        total++;
        if (wbIf.MEMWB_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL alu_ready_pulse got ready=%b exp 0", wbIf.MEMWB_ready);
        end
        applyStimulus(1'b0, 1'b0, 8'd64, 1'b0, 64'h55, 64'h0, 6'd7, 1'b1, 1'b1);
        total++;
        if (wbIf.MEMWB_ready !== 1'b1 || wbIf.MEMWB_ecall !== 1'b1) begin
            bad++;
            $display("[TB] FAIL alu_ecall got ready=%b ecall=%b exp 1/1", wbIf.MEMWB_ready, wbIf.MEMWB_ecall);
        end
    endtask

    task automatic test_rd_zero();
        applyStimulus(1'b0, 1'b0, 8'd64, 1'b0, 64'h99, 64'h0, 6'd0, 1'b1, 1'b0);
        total++;
        if (wbIf.MEMWB_ready !== 1'b1 || wbIf.MEMWB_wbactive !== 1'b0 || exIf.MEMEX_wbactive !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rd_zero got ready=%b wbwb=%b exwb=%b exp 1/0/0",
                     wbIf.MEMWB_ready, wbIf.MEMWB_wbactive, exIf.MEMEX_wbactive);
        end
    endtask

    task automatic test_load_byte();
        exp_t e;
        int   st;
        bit   to, fe;
        gntDelay = 1;
        memData  = 64'h00000000_80000000;
        for (int u = 0; u < 2; u++) begin
            sbQ.push_back('{rdval: expLoad(memData, 3'd3, 8'd8, u[0]), checkVal: 1'b1, wb: 1'b1,
                            fault: 1'b0, rd: 6'd10});
            applyStimulus(1'b1, 1'b1, 8'd8, u[0], 64'h1003, 64'h0, 6'd10, 1'b1, 1'b0);
            waitReady(20, st, to, fe);
            e = sbQ.pop_front();
            total++;
            if (to || st != gntDelay + 2) begin
                bad++;
                $display("[TB] FAIL lb_stall u=%0d got timeout=%b stall=%0d exp %0d", u, to, st, gntDelay + 2);
            end
            total++;
            if (wbIf.MEMWB_rdval !== e.rdval || wbIf.MEMWB_wbactive !== e.wb || wbIf.mem_fault !== 1'b0) begin
                bad++;
                $display("[TB] FAIL lb_value u=%0d got val=%h wb=%b flt=%b exp val=%h wb=%b flt=0",
                         u, wbIf.MEMWB_rdval, wbIf.MEMWB_wbactive, wbIf.mem_fault, e.rdval, e.wb);
            end
            total++;
            if (gotAddr !== 64'h1000 || gotWe !== 1'b0) begin
                bad++;
                $display("[TB] FAIL lb_addr got addr=%h we=%b exp 1000/0", gotAddr, gotWe);
            end
        end
    endtask

    task automatic test_store_half();
        exp_t e;
        int   st;
        bit   to, fe;
        gntDelay = 0;
        sbQ.push_back('{rdval: 64'h0, checkVal: 1'b0, wb: 1'b0, fault: 1'b0, rd: 6'd3});
        applyStimulus(1'b1, 1'b0, 8'd16, 1'b0, 64'h2006, 64'hBEEF, 6'd3, 1'b1, 1'b0);
        waitReady(20, st, to, fe);
        e = sbQ.pop_front();
        total++;
        if (to || st != gntDelay + 1 || wbIf.MEMWB_wbactive !== e.wb || wbIf.mem_fault !== e.fault) begin
            bad++;
            $display("[TB] FAIL sh_done got timeout=%b stall=%0d wb=%b flt=%b exp stall=%0d wb=0 flt=0",
                     to, st, wbIf.MEMWB_wbactive, wbIf.mem_fault, gntDelay + 1);
        end
        total++;
        if (gotAddr !== 64'h2000 || gotStrb !== expStrb(3'd6, 8'd16) || gotWe !== 1'b1 ||
            gotWdata !== expWdata(64'hBEEF, 3'd6)) begin
            bad++;
            $display("[TB] FAIL sh_bus got addr=%h strb=%h we=%b wdata=%h exp 2000/%h/1/%h",
                     gotAddr, gotStrb, gotWe, gotWdata, expStrb(3'd6, 8'd16), expWdata(64'hBEEF, 3'd6));
        end
    endtask

    task automatic test_load_fwd();
        exp_t e;
        int   st;
        bit   to, fe;
        gntDelay  = 4;
        addrMoved = 0;
        memData   = {$urandom, $urandom};
        sbQ.push_back('{rdval: expLoad(memData, 3'd0, 8'd0, 1'b0), checkVal: 1'b1, wb: 1'b1,
                        fault: 1'b0, rd: 6'd12});
        applyStimulus(1'b1, 1'b1, 8'd0, 1'b0, 64'h4008, 64'h0, 6'd12, 1'b1, 1'b0);
        waitReady(30, st, to, fe);
        e = sbQ.pop_front();
        total++;
        if (to || st != gntDelay + 2 || addrMoved || fe) begin
            bad++;
            $display("[TB] FAIL ld_hold got timeout=%b stall=%0d moved=%b earlyfwd=%b exp 0/%0d/0/0",
                     to, st, addrMoved, fe, gntDelay + 2);
        end
        total++;
        if (exIf.MEMEX_rdval !== e.rdval || exIf.MEMEX_wbactive !== 1'b1 || exIf.MEMEX_rd !== e.rd ||
            gotAddr !== 64'h4008) begin
            bad++;
            $display("[TB] FAIL ld_forward got val=%h wb=%b rd=%0d addr=%h exp val=%h wb=1 rd=%0d addr=4008",
                     exIf.MEMEX_rdval, exIf.MEMEX_wbactive, exIf.MEMEX_rd, gotAddr, e.rdval, e.rd);
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        int          st, kind, nb, expSt;
        bit          to, fe;
        logic [7:0]  size;
        logic [2:0]  off;
        logic [63:0] alu, rs2;
        logic [5:0]  rd;
        logic        wbact, uns;
        for (int n = 0; n < 24; n++) begin
            kind     = $urandom_range(0, 2);
            gntDelay = $urandom_range(0, 3);
            size     = 8'd8 << $urandom_range(0, 3);
            nb       = bytesOf(size);
            off      = 3'($urandom_range(0, 7) & ~(nb - 1));
            alu      = {32'h0, $urandom & 32'hFFFF_FFF8} | {61'h0, off};
            rs2      = {$urandom, $urandom};
            rd       = 6'($urandom_range(0, 63));
            wbact    = 1'($urandom_range(0, 1));
            uns      = 1'($urandom_range(0, 1));
            memData  = {$urandom, $urandom};
            if (kind == 0) begin
                sbQ.push_back('{rdval: alu, checkVal: 1'b1, wb: wbact && rd != 0, fault: 1'b0, rd: rd});
                expSt = 0;
            end else if (kind == 1) begin
                sbQ.push_back('{rdval: expLoad(memData, off, size, uns), checkVal: 1'b1,
                                wb: wbact && rd != 0, fault: 1'b0, rd: rd});
                expSt = gntDelay + 2;
            end else begin
                sbQ.push_back('{rdval: 64'h0, checkVal: 1'b0, wb: 1'b0, fault: 1'b0, rd: rd});
                expSt = gntDelay + 1;
            end
            applyStimulus(kind != 0, kind == 1, size, uns, alu, rs2, rd, wbact, 1'b0);
            waitReady(20, st, to, fe);
            e = sbQ.pop_front();
            total++;
            if (to || st != expSt || wbIf.MEMWB_wbactive !== e.wb || wbIf.mem_fault !== e.fault ||
                wbIf.MEMWB_rd !== e.rd || (e.checkVal && wbIf.MEMWB_rdval !== e.rdval)) begin
                bad++;
                $display("[TB] FAIL b2b_%0d kind=%0d got to=%b st=%0d wb=%b flt=%b rd=%0d val=%h exp st=%0d wb=%b rd=%0d val=%h",
                         n, kind, to, st, wbIf.MEMWB_wbactive, wbIf.mem_fault, wbIf.MEMWB_rd,
                         wbIf.MEMWB_rdval, expSt, e.wb, e.rd, e.rdval);
            end
            if (kind == 2) begin
                total++;
                if (gotStrb !== expStrb(off, size) || gotWdata !== expWdata(rs2, off) ||
                    gotAddr !== {alu[63:3], 3'b000}) begin
                    bad++;
                    $display("[TB] FAIL b2b_store_%0d got strb=%h wdata=%h addr=%h exp %h/%h/%h", n,
                             gotStrb, gotWdata, gotAddr, expStrb(off, size), expWdata(rs2, off),
                             {alu[63:3], 3'b000});
                end
            end
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        int   st;
        bit   to, fe;
        noGnt = 1;
        sbQ.push_back('{rdval: 64'h0, checkVal: 1'b0, wb: 1'b0, fault: 1'b1, rd: 6'd8});
        applyStimulus(1'b1, 1'b1, 8'd32, 1'b0, 64'h5000, 64'h0, 6'd8, 1'b1, 1'b0);
        waitReady(300, st, to, fe);
        e = sbQ.pop_front();
        noGnt = 0;
        total++;
        if (to || st != 255 || wbIf.mem_fault !== e.fault || wbIf.MEMWB_wbactive !== e.wb) begin
            bad++;
            $display("[TB] FAIL timeout_fault got to=%b stall=%0d flt=%b wb=%b exp 0/255/1/0",
                     to, st, wbIf.mem_fault, wbIf.MEMWB_wbactive);
        end
        @(negedge clk);
        total++;
        if (wbIf.mem_fault !== 1'b0 || exIf.MEMEX_stall !== 1'b0 || dmemIf.dmem_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL timeout_after got flt=%b stall=%b req=%b exp 0/0/0",
                     wbIf.mem_fault, exIf.MEMEX_stall, dmemIf.dmem_req);
        end
    endtask

    task automatic test_reset_in_wait();
        bit sawReady;
        gntDelay = 0;
        noRvalid = 1;
        memData  = 64'h1111_2222_3333_4444;
        applyStimulus(1'b1, 1'b1, 8'd64, 1'b0, 64'h6000, 64'h0, 6'd9, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        total++;
        if (exIf.MEMEX_stall !== 1'b1 || dmemIf.dmem_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rst_wait_enter got stall=%b req=%b exp 1/0", exIf.MEMEX_stall, dmemIf.dmem_req);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (exIf.MEMEX_stall !== 1'b0 || wbIf.MEMWB_rd !== 6'd0 || wbIf.MEMWB_rdval !== 64'h0) begin
            bad++;
            $display("[TB] FAIL rst_wait_clear got stall=%b rd=%0d val=%h exp 0/0/0",
                     exIf.MEMEX_stall, wbIf.MEMWB_rd, wbIf.MEMWB_rdval);
        end
        noRvalid = 0;
        sawReady = 0;
        repeat (4) begin
            @(negedge clk);
            if (wbIf.MEMWB_ready || wbIf.MEMWB_wbactive || exIf.MEMEX_stall) sawReady = 1;
        end
        total++;
        if (sawReady || wbIf.MEMWB_rdval !== 64'h0 || pendRvalid) begin
            bad++;
            $display("[TB] FAIL rst_late_rvalid got activity=%b val=%h pending=%b exp 0/0/0",
                     sawReady, wbIf.MEMWB_rdval, pendRvalid);
        end
    endtask

    task automatic test_misalign();
        exp_t e;
        int   st, reqBefore;
        bit   to, fe;
        gntDelay  = 0;
        memData   = 64'h8899_AABB_CCDD_EEFF;
        reqBefore = reqCycles;
`ifdef MEM_MISALIGN_TRAP_EN
        sbQ.push_back('{rdval: 64'h0, checkVal: 1'b0, wb: 1'b0, fault: 1'b1, rd: 6'd4});
        applyStimulus(1'b1, 1'b1, 8'd32, 1'b0, 64'h3002, 64'h0, 6'd4, 1'b1, 1'b0);
        waitReady(5, st, to, fe);
        e = sbQ.pop_front();
        total++;
        if (to || st != 0 || wbIf.mem_fault !== e.fault || wbIf.MEMWB_wbactive !== e.wb ||
            reqCycles != reqBefore) begin
            bad++;
            $display("[TB] FAIL misalign_trap got to=%b stall=%0d flt=%b wb=%b reqs=%0d exp 0/0/1/0/0",
                     to, st, wbIf.mem_fault, wbIf.MEMWB_wbactive, reqCycles - reqBefore);
        end
`else
        for (int k = 0; k < 2; k++) begin
            logic [63:0] a;
            a = (k == 0) ? 64'h3002 : 64'h3006;
            sbQ.push_back('{rdval: expLoad(memData, a[2:0], 8'd32, 1'b0), checkVal: 1'b1, wb: 1'b1,
                            fault: 1'b0, rd: 6'd4});
            applyStimulus(1'b1, 1'b1, 8'd32, 1'b0, a, 64'h0, 6'd4, 1'b1, 1'b0);
            waitReady(20, st, to, fe);
            e = sbQ.pop_front();
            total++;
            if (to || reqCycles == reqBefore || wbIf.mem_fault !== e.fault || wbIf.MEMWB_rdval !== e.rdval) begin
                bad++;
                $display("[TB] FAIL misalign_lw_%0d got to=%b flt=%b val=%h exp 0/0/%h",
                         k, to, wbIf.mem_fault, wbIf.MEMWB_rdval, e.rdval);
            end
        end
        sbQ.push_back('{rdval: 64'h0, checkVal: 1'b0, wb: 1'b0, fault: 1'b0, rd: 6'd4});
        applyStimulus(1'b1, 1'b0, 8'd32, 1'b0, 64'h3006, 64'hDEADBEEF, 6'd4, 1'b0, 1'b0);
        waitReady(20, st, to, fe);
        e = sbQ.pop_front();
        total++;
        if (to || wbIf.mem_fault !== e.fault || gotStrb !== expStrb(3'd6, 8'd32) ||
            gotWdata !== expWdata(64'hDEADBEEF, 3'd6)) begin
            bad++;
            $display("[TB] FAIL misalign_sw got to=%b flt=%b strb=%h wdata=%h exp 0/0/%h/%h",
                     to, wbIf.mem_fault, gotStrb, gotWdata, expStrb(3'd6, 8'd32),
                     expWdata(64'hDEADBEEF, 3'd6));
        end
`endif
    endtask

    initial begin
        reset               = 1'b1;
        exIf.EXMEM_ready    = 1'b0;
        exIf.exmm_aluresult = '0;
        exIf.EXMEM_rs2      = '0;
        exIf.dest_reg       = '0;
        exIf.mem_active     = 1'b0;
        exIf.load           = 1'b0;
        exIf.ldst_size      = '0;
        exIf.ldst_unsign    = 1'b0;
        exIf.EXMEM_wbactive = 1'b0;
        exIf.EXMEM_ecall    = 1'b0;
        @(negedge clk);
        test_reset();
        test_alu();
        test_rd_zero();
        test_load_byte();
        test_store_half();
        test_load_fwd();
        test_back_to_back();
        test_timeout();
        test_reset_in_wait();
        test_misalign();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
